// File: rtl/if_fetch_stage_if.sv
// ----------------------------------------------------------------------------
// if_fetch_stage_if
//   Instruction-memory request bus between the fetch stage (master) and the
//   instruction memory (slave).
//
//   Handshake: imem_req is held high for a request and imem_addr stays stable
//   while imem_req=1 and imem_ack=0. The memory answers with imem_ack=1 and
//   imem_rdata valid in the same cycle. The transfer completes on the rising
//   edge where imem_req && imem_ack are both high. imem_ack may already be high
//   in the first cycle of imem_req, which is a zero-wait access. At most one
//   request is outstanding at any time.
//
//   Signals
//     imem_req   master -> slave  request valid
//     imem_addr  master -> slave  byte address of the instruction word
//     imem_ack   slave  -> master response valid
//     imem_rdata slave  -> master instruction word, valid with imem_ack
// ----------------------------------------------------------------------------
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage that feeds the IF/ID pipeline register. It holds
//   the fetch PC and issues at most one outstanding request to instruction
//   memory. Returned words go into a 2-entry {pc, inst} FIFO whose head is
//   shown directly on IF_PC/IF_INST. It handles hazard stalls (pc_write=0) and
//   branch/jump redirects from ID. When the FIFO is empty it outputs an
//   all-zero NOP bubble.
//
// Parameters
//   RESET_PC   fetch address loaded on reset
//   PC_STEP    byte increment per sequential fetch
//
// Ports
//   clk        in   clock, all state changes on posedge
//   rst        in   synchronous active-high reset
//   pc_write   in   1 = IF/ID consumes IF_INST this cycle, 0 = hazard stall
//   PC_src     in   redirect request from ID
//   PC_target  in   redirect address, used when PC_src=1
//   imem       if   master side of the instruction-memory bus
//   IF_valid   out  FIFO head valid
//   IF_PC      out  PC of FIFO head, 0 when empty
//   IF_INST    out  instruction at FIFO head, 0 (NOP) when empty
//   IF_FLUSH   out  copy of PC_src, IF/ID clears on IF_FLUSH && write
//   dbg_state  out  current FSM state (0 IDLE, 1 BUSY, 2 DRAIN)
//
// Optional feature (macro IF_PERF_CNT_EN)
//   perf_fetched  out  words pushed into the FIFO, wraps at 2^32
//   perf_bubbles  out  cycles with pc_write & !IF_valid & !PC_src
// ----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pc_write,
    input  logic                    PC_src,
    input  logic [31:0]             PC_target,
    if_fetch_stage_if.master        imem,
    output logic                    IF_valid,
    output logic [31:0]             IF_PC,
    output logic [31:0]             IF_INST,
    output logic                    IF_FLUSH,
    output logic [1:0]              dbg_state
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]             perf_fetched,
    output logic [31:0]             perf_bubbles
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [1:0]  occ_q, occ_d;
    logic [31:0] ent_pc_q   [2];
    logic [31:0] ent_pc_d   [2];
    logic [31:0] ent_inst_q [2];
    logic [31:0] ent_inst_d [2];

    logic        pop;
    logic        push;
    logic        flush;
    logic [1:0]  occ_next;
    logic        req_c;
    logic [31:0] addr_c;

    // Head is always slot 0. A redirect blocks the pop because the head
    // belongs to the wrong path and is thrown away.
    assign IF_valid = (occ_q != 2'd0);
    assign IF_PC    = IF_valid ? ent_pc_q[0]   : 32'd0;
    assign IF_INST  = IF_valid ? ent_inst_q[0] : 32'd0;
    assign IF_FLUSH = PC_src;
    assign pop      = pc_write & IF_valid & ~PC_src;
    assign occ_next = occ_q - {1'b0, pop};

    assign imem.imem_req  = req_c;
    assign imem.imem_addr = addr_c;
    assign dbg_state      = state_q;

    // ------------------------------------------------------------------
    // FSM next state / outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        push         = 1'b0;
        flush        = 1'b0;
        req_c        = 1'b0;
        addr_c       = pc_q;

        case (state_q)
            ST_IDLE: begin
                if (PC_src) begin
                    pc_d    = PC_target;
                    flush   = 1'b1;
                    state_d = ST_BUSY;
                end else if (occ_next <= 2'd1) begin
                    // A free slot is guaranteed for the word we are about to request.
                    state_d = ST_BUSY;
                end
            end

            ST_BUSY: begin
                req_c = 1'b1;
                if (imem.imem_ack) begin
                    if (!PC_src) begin
                        push    = 1'b1;
                        pc_d    = pc_q + PC_STEP;
                        // Keep fetching only if a slot stays free after this push.
                        state_d = (occ_next == 2'd0) ? ST_BUSY : ST_IDLE;
                    end else begin
                        pc_d  = PC_target;
                        flush = 1'b1;
                    end
                end else if (PC_src) begin
                    // The old request must still finish at its original address,
                    // so that address is kept apart from the new PC.
                    pc_d         = PC_target;
                    flush        = 1'b1;
                    drain_addr_d = pc_q;
                    state_d      = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                req_c  = 1'b1;
                addr_c = drain_addr_q;
                if (PC_src) begin
                    pc_d  = PC_target;
                    flush = 1'b1;
                end
                if (imem.imem_ack) begin
                    state_d = ST_BUSY;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO next state. Slot 0 is the head and entries shift down on pop.
    // push and flush never occur together (push needs !PC_src).
    // ------------------------------------------------------------------
    always_comb begin
        occ_d         = occ_q;
        ent_pc_d[0]   = ent_pc_q[0];
        ent_pc_d[1]   = ent_pc_q[1];
        ent_inst_d[0] = ent_inst_q[0];
        ent_inst_d[1] = ent_inst_q[1];

        if (flush) begin
            occ_d = 2'd0;
        end else if (push && pop) begin
            if (occ_q == 2'd2) begin
                ent_pc_d[0]   = ent_pc_q[1];
                ent_inst_d[0] = ent_inst_q[1];
                ent_pc_d[1]   = pc_q;
                ent_inst_d[1] = imem.imem_rdata;
            end else begin
                ent_pc_d[0]   = pc_q;
                ent_inst_d[0] = imem.imem_rdata;
            end
        end else if (push) begin
            // The issue rule keeps occ_q at 0 or 1 here, so bit 0 selects the slot.
            ent_pc_d[occ_q[0]]   = pc_q;
            ent_inst_d[occ_q[0]] = imem.imem_rdata;
            occ_d                = occ_q + 2'd1;
        end else if (pop) begin
            ent_pc_d[0]   = ent_pc_q[1];
            ent_inst_d[0] = ent_inst_q[1];
            occ_d         = occ_q - 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            drain_addr_q  <= 32'd0;
            occ_q         <= 2'd0;
            ent_pc_q[0]   <= 32'd0;
            ent_pc_q[1]   <= 32'd0;
            ent_inst_q[0] <= 32'd0;
            ent_inst_q[1] <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drain_addr_q  <= drain_addr_d;
            occ_q         <= occ_d;
            ent_pc_q[0]   <= ent_pc_d[0];
            ent_pc_q[1]   <= ent_pc_d[1];
            ent_inst_q[0] <= ent_inst_d[0];
            ent_inst_q[1] <= ent_inst_d[1];
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_bubbles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= 32'd0;
            perf_bubbles_q <= 32'd0;
        end else begin
            if (push) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (pc_write && !IF_valid && !PC_src) begin
                perf_bubbles_q <= perf_bubbles_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
`timescale 1ns/1ps
module tb_if_fetch_stage;

    localparam int STARVE_LIMIT = 12;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic        clk;
    logic        rst;
    logic        pc_write;
    logic        PC_src;
    logic [31:0] PC_target;

    logic        IF_valid;
    logic [31:0] IF_PC;
    logic [31:0] IF_INST;
    logic        IF_FLUSH;
    logic [1:0]  dbg_state;

    logic        pc_write_w;
    logic        PC_src_w;
    logic [31:0] PC_target_w;
    logic        IF_valid_w;
    logic [31:0] IF_PC_w;
    logic [31:0] IF_INST_w;
    logic        IF_FLUSH_w;
    logic [1:0]  dbg_state_w;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
    logic [31:0] perf_fetched_w;
    logic [31:0] perf_bubbles_w;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    if_fetch_stage_if imem ();
    if_fetch_stage_if imem_w ();

    if_fetch_stage u_dut (
        .clk       (clk),
        .rst       (rst),
        .pc_write  (pc_write),
        .PC_src    (PC_src),
        .PC_target (PC_target),
        .imem      (imem),
        .IF_valid  (IF_valid),
        .IF_PC     (IF_PC),
        .IF_INST   (IF_INST),
        .IF_FLUSH  (IF_FLUSH),
        .dbg_state (dbg_state)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_bubbles (perf_bubbles)
`endif
    );

    // Second instance exercising a reset PC near the top of the address space.
    if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_dut_w (
        .clk       (clk),
        .rst       (rst),
        .pc_write  (pc_write_w),
        .PC_src    (PC_src_w),
        .PC_target (PC_target_w),
        .imem      (imem_w),
        .IF_valid  (IF_valid_w),
        .IF_PC     (IF_PC_w),
        .IF_INST   (IF_INST_w),
        .IF_FLUSH  (IF_FLUSH_w),
        .dbg_state (dbg_state_w)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched_w),
        .perf_bubbles (perf_bubbles_w)
`endif
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // ------------------------------------------------------------------
    // Instruction memory models
    // ------------------------------------------------------------------
    int unsigned mem_cnt = 0;
    int unsigned mem_lat = 0;
    int unsigned fix_lat = 0;
    logic        rand_lat = 1'b0;

    always_comb begin
        imem.imem_ack   = imem.imem_req && (mem_cnt >= mem_lat);
        imem.imem_rdata = imem.imem_ack ? word_of(imem.imem_addr) : 32'hDEAD_BEEF;
    end

    always_ff @(posedge clk) begin
        if (rst || !imem.imem_req || imem.imem_ack) begin
            mem_cnt <= 0;
            mem_lat <= rand_lat ? $urandom_range(0, 3) : fix_lat;
        end else begin
            mem_cnt <= mem_cnt + 1;
        end
    end

    always_comb begin
        imem_w.imem_ack   = imem_w.imem_req;
        imem_w.imem_rdata = word_of(imem_w.imem_addr);
    end

    // ------------------------------------------------------------------
    // Reference model: the consumed stream must be consecutive PCs from the
    // reset PC or the last redirect target, each carrying its memory word.
    // ------------------------------------------------------------------
    logic [31:0] exp_pc = 32'd0;
    logic        prev_pending = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    int          starve = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_pc       = 32'd0;
            prev_pending = 1'b0;
            starve       = 0;
        end else begin
            check("flush_eq_pcsrc", IF_FLUSH, PC_src);
            if (!IF_valid) begin
                check("bubble_pc", IF_PC, 32'd0);
                check("bubble_inst", IF_INST, 32'd0);
            end
            if (prev_pending && imem.imem_req) begin
                check("addr_hold", imem.imem_addr, prev_addr);
            end
            if (PC_src) begin
                exp_pc = PC_target;
                starve = 0;
            end else if (pc_write && IF_valid) begin
                check("stream_pc", IF_PC, exp_pc);
                check("stream_inst", IF_INST, word_of(exp_pc));
                exp_pc = exp_pc + 32'd4;
                starve = 0;
            end else if (pc_write) begin
                starve++;
                check("no_starve", (starve <= STARVE_LIMIT), 1'b1);
            end
            prev_pending = imem.imem_req && !imem.imem_ack;
            prev_addr    = imem.imem_addr;
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic do_reset();
        rst    = 1'b1;
        PC_src = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [31:0] exp_q   [$];
    logic [31:0] exp_w_q [$];
    logic [31:0] held_pc;
    logic [31:0] rnd;
    logic        got;

    initial begin
        rst         = 1'b1;
        pc_write    = 1'b1;
        PC_src      = 1'b0;
        PC_target   = 32'd0;
        pc_write_w  = 1'b1;
        PC_src_w    = 1'b0;
        PC_target_w = 32'd0;

        // Zero-wait fetch sequence and first-valid latency
        rand_lat = 1'b0;
        fix_lat  = 0;
        do_reset();
        @(negedge clk);
        check("rst_req", imem.imem_req, 1'b0);
        check("rst_valid", IF_valid, 1'b0);
        check("rst_pc", IF_PC, 32'd0);
        check("rst_inst", IF_INST, 32'd0);
        check("rst_state", dbg_state, 2'd0);
        check("rst_req_w", imem_w.imem_req, 1'b0);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(32'd4 * i);
            exp_w_q.push_back(32'hFFFF_FFF8 + 32'd4 * i);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) check("valid_not_yet", IF_valid, 1'b0);
            if (i == 1) check("first_valid", IF_valid, 1'b1);
            check("seq_req", imem.imem_req, 1'b1);
            check("seq_addr", imem.imem_addr, exp_q.pop_front());
            check("wrap_addr", imem_w.imem_addr, exp_w_q.pop_front());
        end

        // Stall: FIFO fills, request stops, head holds
        next_cycle();
        pc_write = 1'b0;
        @(negedge clk);
        held_pc = IF_PC;
        check("stall_valid", IF_valid, 1'b1);
        repeat (4) @(negedge clk);
        check("stall_req_drop", imem.imem_req, 1'b0);
        check("stall_valid_hold", IF_valid, 1'b1);
        check("stall_pc_hold", IF_PC, held_pc);
        check("stall_inst_hold", IF_INST, word_of(held_pc));
        next_cycle();
        pc_write = 1'b1;
        repeat (12) @(negedge clk);

        // Redirect in BUSY before the ack, 3-cycle memory
        fix_lat = 3;
        do_reset();
        next_cycle();
        next_cycle();
        PC_src    = 1'b1;
        PC_target = 32'h40;
        @(negedge clk);
        check("busy_redir_flush", IF_FLUSH, 1'b1);
        check("busy_redir_noack", imem.imem_ack, 1'b0);
        next_cycle();
        PC_src = 1'b0;
        @(negedge clk);
        check("drain_state", dbg_state, 2'd2);
        check("drain_addr_old", imem.imem_addr, 32'd0);
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (imem.imem_ack) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("drain_ack_seen", got, 1'b1);
        @(negedge clk);
        check("target_req", imem.imem_req, 1'b1);
        check("target_addr", imem.imem_addr, 32'h40);
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (IF_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("target_valid_seen", got, 1'b1);
        check("target_first_pc", IF_PC, 32'h40);
        check("target_first_inst", IF_INST, word_of(32'h40));

        // Redirect coincident with ack and pop, zero-wait
        fix_lat = 0;
        do_reset();
        repeat (4) next_cycle();
        PC_src    = 1'b1;
        PC_target = 32'h100;
        @(negedge clk);
        check("coinc_ack", imem.imem_ack, 1'b1);
        check("coinc_valid", IF_valid, 1'b1);
        next_cycle();
        PC_src = 1'b0;
        @(negedge clk);
        check("coinc_empty", IF_valid, 1'b0);
        check("coinc_nop", IF_INST, 32'd0);
        check("coinc_addr", imem.imem_addr, 32'h100);
        @(negedge clk);
        check("coinc_first_valid", IF_valid, 1'b1);
        check("coinc_first_pc", IF_PC, 32'h100);

        // Reset while a request is pending
        fix_lat = 3;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        check("midrst_pending", imem.imem_req, 1'b1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_req", imem.imem_req, 1'b0);
        check("midrst_state", dbg_state, 2'd0);
        check("midrst_valid", IF_valid, 1'b0);

        // Randomized traffic against the stream model
        for (int seg = 0; seg < 3; seg++) begin
            rand_lat = 1'b1;
            do_reset();
            for (int c = 0; c < 400; c++) begin
                next_cycle();
                pc_write = ($urandom_range(0, 3) != 0);
                PC_src   = ($urandom_range(0, 15) == 0);
                rnd      = $urandom();
                if (seg == 2 && rnd[0])
                    PC_target = 32'hFFFF_FFF0;
                else
                    PC_target = {rnd[31:2], 2'b00};
            end
            next_cycle();
            PC_src   = 1'b0;
            pc_write = 1'b1;
            repeat (12) @(negedge clk);
        end

`ifdef IF_PERF_CNT_EN
        // Counters: 11 consuming edges after reset give 2 bubbles and 10 fetches
        rand_lat = 1'b0;
        fix_lat  = 0;
        pc_write = 1'b1;
        do_reset();
        repeat (11) next_cycle();
        @(negedge clk);
        check("perf_fetched", perf_fetched, 32'd10);
        check("perf_bubbles", perf_bubbles, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule
